disp_scan_arbiter: RTL

Owns the 8-digit seven-segment display in the clock design and shares it between the set-time editor, the current-time view and the alarm view. Selects the active source from `mode` and `alarm_req`, and switches sources only on scan-frame boundaries through one blank frame. Generates the digit scan (`chs`), applies edit-field blinking, and drives `oout`/`chs` directly as registered outputs. It replaces the plain mode mux at the top level.

---
 rtl/disp_pkg.sv | 36 +++
 rtl/disp_scan_timer.sv | 72 +++++++
 rtl/disp_scan_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the seven-segment display arbiter.
//   - source encoding driven on active_src
//   - FSM state type (show a source / one blank frame)
//   - blank segment pattern and digit count
//   - req_src(): maps mode/alarm_req to the requested source
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_SET   = 2'd1;
    localparam logic [1:0] SRC_CURR  = 2'd2;
    localparam logic [1:0] SRC_ALARM = 2'd3;

    typedef enum logic {
        StShow  = 1'b0,
        StBlank = 1'b1
    } disp_state_e;

    // Alarm preempts the mode selection only when the alarm view is built in.
    function automatic logic [1:0] req_src(input logic [3:0] mode,
                                           input logic       alarm_req,
                                           input logic       alarm_en);
        if (alarm_en && alarm_req) begin
            return SRC_ALARM;
        end else if (mode == 4'd0) begin
            return SRC_SET;
        end else if (mode == 4'd1) begin
            return SRC_CURR;
        end
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// disp_scan_timer: digit scan and blink timebase.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   idx_o [2:0]       : digit currently scanned, held SCAN_DIV cycles each
//   frame_tick_o      : high on the last cycle of each 8-digit frame
//   phase_o           : blink phase, toggles every BLINK_FRAMES frames
module disp_scan_timer
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [2:0] idx_o,
    output logic       frame_tick_o,
    output logic       phase_o
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             phase_q, phase_d;
    logic             tick;

    always_comb begin
        div_d   = div_q + 1'b1;
        idx_d   = idx_q;
        frm_d   = frm_q;
        phase_d = phase_q;
        tick    = (idx_q == IDX_LAST) && (div_q == DIV_LAST);

        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;  // 3-bit wrap 7 -> 0
        end

        if (tick) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end

    assign idx_o        = idx_q;
    assign frame_tick_o = tick;
    assign phase_o      = phase_q;

endmodule

// File: rtl/disp_scan_arbiter.sv
// disp_scan_arbiter: owns the 8-digit seven-segment display and shares it
// between set-time, current-time and alarm views. Sources change only at a
// frame boundary, always through one blank frame.
//   clk, rst              : clock, synchronous active-high reset
//   mode [3:0]            : 0 set-time, 1 current-time, else no source
//   alarm_req             : alarm view request, preempts mode
//   set_seg/curr_seg/alarm_seg [63:0] : segment bytes, digit i = [8i+7:8i]
//   set_blink [7:0]       : set-time digits to blink
//   oout [7:0], chs [7:0] : registered segment pattern / one-hot digit enable
//   active_src [1:0]      : source shown (0 in the blank frame)
//   frame_tick            : registered end-of-frame pulse
// Build option: define DISP_ALARM_EN to arbitrate and flash the alarm view;
// otherwise alarm_req and alarm_seg have no effect.
module disp_scan_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mode,
    input  logic        alarm_req,
    input  logic [63:0] set_seg,
    input  logic [7:0]  set_blink,
    input  logic [63:0] curr_seg,
    input  logic [63:0] alarm_seg,
    output logic [7:0]  oout,
    output logic [7:0]  chs,
    output logic [1:0]  active_src,
    output logic        frame_tick
);

`ifdef DISP_ALARM_EN
    localparam logic ALARM_EN = 1'b1;
`else
    localparam logic ALARM_EN = 1'b0;
`endif

    logic [2:0]  idx;
    logic        tick;
    logic        phase;

    disp_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk_i        (clk),
        .rst_i        (rst),
        .idx_o        (idx),
        .frame_tick_o (tick),
        .phase_o      (phase)
    );

    disp_state_e state_q, state_d;
    logic [1:0]  cur_q, cur_d;
    logic [7:0]  oout_q, oout_d;
    logic [7:0]  chs_q, chs_d;
    logic [1:0]  src_q, src_d;
    logic        tick_q;

    logic [1:0]  req;
    logic [63:0] src_bus;
    logic [7:0]  digit_seg;
    logic        blank_digit;

    always_comb begin
        req = req_src(mode, alarm_req, ALARM_EN);

        state_d = state_q;
        cur_d   = cur_q;
        if (tick) begin
            unique case (state_q)
                StShow: begin
                    // req is only looked at on the frame's last cycle, so
                    // mid-frame glitches that return to cur never blank.
                    if (req != cur_q) begin
                        state_d = StBlank;
                    end
                end
                StBlank: begin
                    state_d = StShow;
                    cur_d   = req;
                end
                default: state_d = StShow;
            endcase
        end

        unique case (cur_q)
            SRC_SET:   src_bus = set_seg;
            SRC_CURR:  src_bus = curr_seg;
            SRC_ALARM: src_bus = alarm_seg;
            default:   src_bus = '0;
        endcase
        digit_seg = src_bus[{idx, 3'b000} +: 8];

        blank_digit = 1'b0;
        if ((cur_q == SRC_SET) && phase && set_blink[idx]) begin
            blank_digit = 1'b1;
        end
        if (ALARM_EN && (cur_q == SRC_ALARM) && phase) begin
            blank_digit = 1'b1;
        end

        oout_d = SEG_BLANK;
        chs_d  = '0;
        src_d  = SRC_NONE;
        if (state_q == StShow) begin
            src_d = cur_q;
            if (cur_q != SRC_NONE) begin
                chs_d  = 8'b1 << idx;
                oout_d = blank_digit ? SEG_BLANK : digit_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StShow;
            cur_q   <= SRC_NONE;
            oout_q  <= SEG_BLANK;
            chs_q   <= '0;
            src_q   <= SRC_NONE;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            oout_q  <= oout_d;
            chs_q   <= chs_d;
            src_q   <= src_d;
            tick_q  <= tick;
        end
    end

    assign oout       = oout_q;
    assign chs        = chs_q;
    assign active_src = src_q;
    assign frame_tick = tick_q;

endmodule
